// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and defaults for the memory bus arbiter
// Purpose: arbiter state encoding, default bus widths and the reset PC constant.
// Ports: none (package).
package mem_bus_pkg;

    localparam int          MEM_ADDR_W = 32;
    localparam int          MEM_DATA_W = 32;
    localparam logic [31:0] RESET_PC   = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FE_BUSY = 2'd1,
        MS_BUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// rtl/mem_arb_starve_ctr.sv - saturating fetch-starvation counter
// Purpose: counts mem-stage grants taken while fetch waits, saturating at limit_i.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   inc_i          count one mem-stage grant while fetch is waiting
//   clr_i          clear (fetch granted or fetch no longer requesting); wins over inc_i
//   limit_i        saturation limit
//   below_limit_o  1 while the count is still below limit_i
module mem_arb_starve_ctr
    import mem_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_i,
    input  logic       clr_i,
    input  logic [3:0] limit_i,
    output logic       below_limit_o
);

    logic [3:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            count_q <= 4'd0;
        end else if (inc_i && (count_q < limit_i)) begin
            count_q <= count_q + 4'd1;
        end
    end

    assign below_limit_o = (count_q < limit_i);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch / mem-stage arbiter for the shared memory bus
// Purpose: serialises fetch and mem-stage requests onto one bus, mem stage
//   first, with bounded fetch starvation; steers ack/data back to the owner.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   fe_req/fe_addr -> fe_ack/fe_data    fetch read port
//   ms_req/ms_we/ms_addr/ms_be/ms_wdata -> ms_ack/ms_rdata   mem-stage port
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata, bus_ack/bus_rdata   downstream bus
//   bus_err                             timeout pulse
// Optional: MEM_ARB_TIMEOUT_EN adds a bus wait timeout of TIMEOUT_CYCLES;
//   without it bus_err is tied 0 and the arbiter waits indefinitely.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W         = MEM_ADDR_W,
    parameter int DATA_W         = MEM_DATA_W,
    parameter int FE_STARVE_MAX  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fe_req,
    input  logic [ADDR_W-1:0]   fe_addr,
    output logic                fe_ack,
    output logic [DATA_W-1:0]   fe_data,
    input  logic                ms_req,
    input  logic                ms_we,
    input  logic [ADDR_W-1:0]   ms_addr,
    input  logic [DATA_W/8-1:0] ms_be,
    input  logic [DATA_W-1:0]   ms_wdata,
    output logic                ms_ack,
    output logic [DATA_W-1:0]   ms_rdata,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                bus_err
);

    localparam int BE_W = DATA_W / 8;

    if (FE_STARVE_MAX < 1 || FE_STARVE_MAX > 15 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("mem_arbiter: FE_STARVE_MAX or TIMEOUT_CYCLES out of range");
    end

    arb_state_e        state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;
    logic              drop_q;

    logic idle;
    logic busy;
    logic ms_win_d;
    logic fe_win_d;
    logic starve_below;
    logic timeout;
    logic done;

    assign idle = (state_q == IDLE);
    assign busy = !idle;

    // Mem stage is older in program order, so it wins unless fetch has
    // already been passed over FE_STARVE_MAX times in a row.
    assign ms_win_d = idle && ms_req && (!fe_req || starve_below);
    assign fe_win_d = idle && fe_req && !ms_win_d;

    mem_arb_starve_ctr u_starve (
        .clk           (clk),
        .reset         (reset),
        .inc_i         (ms_win_d && fe_req),
        .clr_i         (fe_win_d || !fe_req),
        .limit_i       (4'(FE_STARVE_MAX)),
        .below_limit_o (starve_below)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] to_cnt_q;

    // Held at zero in IDLE so every busy period starts counting from 0.
    always_ff @(posedge clk) begin
        if (reset || idle) begin
            to_cnt_q <= 8'd0;
        end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
        end
    end

    assign timeout = busy && !reset && !bus_ack &&
                     (to_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // A reset cycle never completes a transaction; the bus is reset with us.
    assign done = busy && !reset && (bus_ack || timeout);

    // A fetch that went away (redirect/flush) still finishes on the bus but
    // must not be acknowledged, including when it drops in the ack cycle.
    assign fe_ack   = (state_q == FE_BUSY) && done && !drop_q && fe_req;
    assign ms_ack   = (state_q == MS_BUSY) && done;
    assign bus_err  = timeout;
    assign fe_data  = timeout ? '0 : bus_rdata;
    assign ms_rdata = timeout ? '0 : bus_rdata;

    assign bus_req   = busy;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    drop_q <= 1'b0;
                    if (ms_win_d) begin
                        state_q <= MS_BUSY;
                        we_q    <= ms_we;
                        addr_q  <= ms_addr;
                        be_q    <= ms_be;
                        wdata_q <= ms_wdata;
                    end else if (fe_win_d) begin
                        state_q <= FE_BUSY;
                        we_q    <= 1'b0;
                        addr_q  <= fe_addr;
                        be_q    <= '1;
                        wdata_q <= '0;
                    end
                end
                FE_BUSY, MS_BUSY: begin
                    if (done) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b0;
                    end else if ((state_q == FE_BUSY) && !fe_req) begin
                        drop_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single memory bus between the fetch stage (instruction reads) and the mem stage (loads/stores). It sits between both pipeline stages and the memory/bus interface. It serialises requests, steers the return ack/data to the winning requester, and bounds fetch starvation. The mem stage has priority by default because it is older in program order.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables are DATA_W/8 bits)
FE_STARVE_MAX, 4, consecutive mem-stage grants allowed while fetch waits; legal range 1..15
TIMEOUT_CYCLES, 255, bus wait limit when MEM_ARB_TIMEOUT_EN is defined; legal range 1..255

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
fe_req  in  1  fetch read request; level, held until fe_ack
fe_addr  in  ADDR_W  fetch address
fe_ack  out  1  one-cycle pulse, fetch data valid
fe_data  out  DATA_W  fetch read data
ms_req  in  1  mem-stage request; level, held until ms_ack
ms_we  in  1  1 = store, 0 = load
ms_addr  in  ADDR_W  mem-stage address
ms_be  in  DATA_W/8  store byte enables
ms_wdata  in  DATA_W  store data
ms_ack  out  1  one-cycle pulse, mem-stage transaction done
ms_rdata  out  DATA_W  load data
bus_req  out  1  downstream request, held until bus_ack
bus_we  out  1  downstream write
bus_addr  out  ADDR_W  downstream address
bus_be  out  DATA_W/8  downstream byte enables
bus_wdata  out  DATA_W  downstream write data
bus_ack  in  1  downstream completion pulse
bus_rdata  in  DATA_W  downstream read data, valid with bus_ack
bus_err  out  1  timeout pulse (tied 0 without MEM_ARB_TIMEOUT_EN)

Behaviour:
- The arbiter has three states: IDLE, FE_BUSY, MS_BUSY.
- Reset: state goes to IDLE. bus_req, fe_ack, ms_ack, bus_err and the starve counter are all 0. Any bus_ack arriving in IDLE is ignored.
- IDLE arbitration, evaluated each cycle:
  - If ms_req=1 and (fe_req=0 or starve<FE_STARVE_MAX): go to MS_BUSY.
  - Else if fe_req=1: go to FE_BUSY.
  - Otherwise stay in IDLE.
- Capture: on the grant edge, the winner's address, we, be and wdata are latched into registers. The bus_* outputs are driven only from these latched registers. For fetch, bus_we=0 and bus_be is all ones.
- bus_req=1 whenever state is FE_BUSY or MS_BUSY. The bus_* outputs are stable until bus_ack.
- Completion:
  - When bus_ack=1 in a busy state, the arbiter combinationally pulses the owner's ack in the same cycle.
  - The owner's data output equals bus_rdata in that cycle.
  - The state returns to IDLE on the next edge.
- Latency and throughput:
  - A request seen in cycle 0 drives bus_req in cycle 1. The earliest requester ack is cycle 1.
  - Throughput is at most one transaction per 2 cycles.
- Starve counter (4 bits):
  - Increments on each MS grant while fe_req=1.
  - Clears on any FE grant, or when fe_req=0.
  - Saturates at FE_STARVE_MAX.
- Fetch drop: if fe_req falls while in FE_BUSY (redirect/flush), the bus transaction still completes. A sticky drop flag suppresses fe_ack for that transaction. The flag clears on return to IDLE.
- ms_req may not drop mid-transaction. This is a protocol rule; the verifier asserts it.
- Simultaneous fe_req and ms_req with starve<FE_STARVE_MAX: MS wins.
- Reset mid-transaction: bus_req drops on the next edge. The downstream is reset by the same signal.
- fe_data and ms_rdata equal bus_rdata at all times. They are only meaningful when qualified by their ack.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - An 8-bit counter runs in the busy states and clears on entering a busy state.
  - If it reaches TIMEOUT_CYCLES without bus_ack, the arbiter pulses bus_err for one cycle and the owner's ack in that same cycle (ms_ack or fe_ack, still subject to the drop flag).
  - The returned data is forced to 0 and the state returns to IDLE.
- Undefined: there is no counter and bus_err is tied 0. The arbiter waits indefinitely.

Decomposition:
- Shared package mem_bus_pkg holds:
  - the arb_state_e enum (IDLE=2'd0, FE_BUSY=2'd1, MS_BUSY=2'd2);
  - the ADDR_W/DATA_W defaults;
  - the reset PC constant 32'h80000000, used by the bench.
- One sub-module, mem_arb_starve_ctr: the saturating starve counter, with increment/clear/limit ports. Everything else stays flat.

Test Plan:
- Single fetch: fe_req=1, fe_addr=0x80000000, bus_ack in cycle 3 with rdata=0x00000013 -> bus_req cycles 1-3, bus_we=0, fe_ack=1 and fe_data=0x13 in cycle 3, ms_ack stays 0.
- Simultaneous: fe_req=ms_req=1, ms_we=1, ms_addr=0x100, ms_be=4'b0011, wdata=0xDEADBEEF, 1-cycle bus -> MS served first with bus_be=0011, then FE. Acks arrive in order ms, fe.
- Starvation: ms_req held high for 10 transactions, fe_req high, FE_STARVE_MAX=4 -> grant order MS,MS,MS,MS,FE,MS,MS,MS,MS,FE.
- Fetch drop: FE_BUSY, fe_req deasserted in cycle 2, bus_ack in cycle 4 -> fe_ack never pulses, state is IDLE in cycle 5, a pending ms_req is granted in cycle 5.
- Reset mid-op: MS_BUSY, reset in cycle 2 -> bus_req=0 from cycle 3, no ms_ack, a later bus_ack is ignored.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): ms load, no bus_ack -> bus_err and ms_ack pulse together with ms_rdata=0 after 8 busy cycles. The next grant proceeds normally.
